axis_m: RTL and testbench

AXIS_M -- requirements
Module: axis_m

---
 rtl/axis_m.sv | 131 +++++++++++++
 tb/tb_axis_m.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_m.sv
// rtl/axis_m.sv - AXI-Stream master with user write FIFO, registered output stage and packet beat counter
module axis_m #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  input  logic              last,
  output logic              ready,
  output logic              tvalid,
  input  logic              tready,
  output logic [DATA_W-1:0] tdata,
  output logic              tlast,
  output logic [15:0]       beats,
  output logic              finish
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // FIFO storage: {last, data} per entry
  logic [DATA_W:0]    r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  // Output stage registers
  logic               r_tvalid;
  logic [DATA_W-1:0]  r_tdata;
  logic               r_tlast;

  // Packet accounting
  logic [15:0]        r_beat_cnt;
  logic [15:0]        r_beats;
  logic               r_finish;

  logic               w_wr;
  logic               w_hs;
  logic               w_fifo_empty;
  logic               w_load;
  logic [DATA_W:0]    w_head;

  // ready comes straight from registered occupancy, so a full FIFO never accepts
  assign ready        = (r_count < FULL_CNT);
  assign w_wr         = valid & ready;
  assign w_hs         = r_tvalid & tready;
  assign w_fifo_empty = (r_count == '0);
  // The stage refills whenever it is empty or its word is leaving this edge
  assign w_load       = (~r_tvalid | w_hs) & ~w_fifo_empty;
  assign w_head       = r_mem[r_rd_ptr];

  assign tvalid = r_tvalid;
  assign tdata  = r_tdata;
  assign tlast  = r_tlast;
  assign beats  = r_beats;
  assign finish = r_finish;

  // Store accepted user words; contents need no reset since occupancy gates them
  always_ff @(posedge aclk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {last, data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy tracks push/pop; simultaneous push and pop leaves it unchanged
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_count <= '0;
    end else begin
      case ({w_wr, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage: load from FIFO head, or go idle after a handshake with nothing queued
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_head[DATA_W-1:0];
      r_tlast  <= w_head[DATA_W];
    end else if (w_hs) begin
      r_tvalid <= 1'b0;
    end
  end

  // Count beats per packet; publish the total and pulse finish on the tlast handshake
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_beat_cnt <= '0;
      r_beats    <= '0;
      r_finish   <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      if (w_hs) begin
        if (r_tlast) begin
          r_beats    <= r_beat_cnt + 16'd1;
          r_beat_cnt <= '0;
          r_finish   <= 1'b1;
        end else begin
          r_beat_cnt <= r_beat_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_m.sv
// tb/tb_axis_m.sv - self-checking bench for axis_m
module tb_axis_m;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          aclk   = 1'b0;
  logic          areset = 1'b0;
  logic [DW-1:0] data   = '0;
  logic          valid  = 1'b0;
  logic          last   = 1'b0;
  logic          tready = 1'b0;
  logic          ready;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic [15:0]   beats;
  logic          finish;

  axis_m #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .aclk   (aclk),
    .areset (areset),
    .data   (data),
    .valid  (valid),
    .last   (last),
    .ready  (ready),
    .tvalid (tvalid),
    .tready (tready),
    .tdata  (tdata),
    .tlast  (tlast),
    .beats  (beats),
    .finish (finish)
  );

  always #5 aclk = ~aclk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // tready source: 0 = low, 1 = high, 2 = random
  int tr_mode = 0;
  always @(posedge aclk) begin
    #1;
    case (tr_mode)
      0:       tready = 1'b0;
      1:       tready = 1'b1;
      default: tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard and model state, all updated at the falling edge
  logic [DW:0]  sb[$];
  int unsigned  fin_q[$];
  logic [DW:0]  exp_w;
  logic [DW:0]  prev_word;
  logic         prev_stall = 1'b0;
  logic [15:0]  model_cnt  = '0;
  logic [15:0]  pend_beats = '0;
  logic         pend       = 1'b0;
  int           cyc = 0, hs_count = 0, hs_mark = 0, first_hs_cyc = 0, last_hs_cyc = 0;

  always @(negedge aclk) begin
    cyc++;
    if (areset) begin
      sb.delete();
      model_cnt  = '0;
      pend       = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (pend || finish) begin
        check("finish_pulse", finish, pend);
        if (pend) check("beats_value", beats, pend_beats);
        if (finish) fin_q.push_back(beats);
      end
      if (prev_stall) begin
        check("stall_tvalid", tvalid, 1'b1);
        check("stall_word", {tlast, tdata}, prev_word);
      end
      pend = 1'b0;
      if (valid && ready) sb.push_back({last, data});
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: got 0x%0h required no beat", {tlast, tdata});
        end else begin
          exp_w = sb.pop_front();
          check("tdata_order", {tlast, tdata}, exp_w);
        end
        if (hs_count == hs_mark) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        hs_count++;
        if (tlast) begin
          pend       = 1'b1;
          pend_beats = model_cnt + 16'd1;
          model_cnt  = '0;
        end else begin
          model_cnt = model_cnt + 16'd1;
        end
      end
      prev_stall = tvalid && !tready;
      prev_word  = {tlast, tdata};
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d, input logic l);
    int   budget;
    logic acc;
    budget = 200;
    acc    = 1'b0;
    data   = d;
    last   = l;
    valid  = 1'b1;
    while (!acc && budget > 0) begin
      @(negedge aclk);
      acc = ready;
      tick();
      budget--;
    end
    if (!acc) begin
      n_total++;
      $display("FAIL write_timeout: got ready=0 required ready=1 for data 0x%0h", d);
    end
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 1000;
    while ((sb.size() != 0 || tvalid || pend) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d words pending required 0", sb.size());
    end
    tick();
  endtask

  typedef struct {
    int len;
    int mode;
    int exp_beats;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int b;
    int bad;
    tbl[0] = '{len: 1,  mode: 2, exp_beats: 1};
    tbl[1] = '{len: 2,  mode: 2, exp_beats: 2};
    tbl[2] = '{len: 16, mode: 2, exp_beats: 16};
    tbl[3] = '{len: 4,  mode: 1, exp_beats: 4};
    tbl[4] = '{len: 7,  mode: 2, exp_beats: 7};

    // Reset values
    #2 areset = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tdata", tdata, 32'h0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_finish", finish, 1'b0);
    check("rst_beats", beats, 16'h0);
    areset = 1'b0;
    tick();
    check("rst_ready", ready, 1'b1);

    // Single word: one-edge latency, beats=1
    tr_mode = 1;
    repeat (2) tick();
    write_word(32'hA5A5_0001, 1'b1);
    check("lat_tvalid_write_edge", tvalid, 1'b0);
    tick();
    check("lat_tvalid_next_edge", tvalid, 1'b1);
    check("lat_tdata", tdata, 32'hA5A5_0001);
    drain();
    check("single_fin_count", fin_q.size(), 1);
    if (fin_q.size() == 1) check("single_beats", fin_q[0], 1);
    fin_q.delete();

    // Backpressure: head word stays on the bus for 5 stalled cycles
    tr_mode = 0;
    repeat (2) tick();
    write_word(32'h11, 1'b0);
    write_word(32'h22, 1'b0);
    write_word(32'h33, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_tvalid", tvalid, 1'b1);
      check("bp_tdata", tdata, 32'h11);
    end
    hs_mark = hs_count;
    tr_mode = 1;
    drain();
    check("bp_beat_count", hs_count - hs_mark, 3);
    check("bp_consecutive", last_hs_cyc - first_hs_cyc, 2);
    check("bp_fin_count", fin_q.size(), 1);
    if (fin_q.size() == 1) check("bp_beats", fin_q[0], 3);
    fin_q.delete();

    // Full: stage + DEPTH queued words, sixth write stalls
    tr_mode = 0;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) write_word(32'h100 + i, 1'b0);
    check("full_ready", ready, 1'b0);
    data  = 32'h105;
    last  = 1'b1;
    valid = 1'b1;
    repeat (3) tick();
    check("full_ready_held", ready, 1'b0);
    check("full_stalled_writes", sb.size(), 5);
    tr_mode = 1;
    write_word(32'h105, 1'b1);
    drain();
    check("full_fin_count", fin_q.size(), 1);
    if (fin_q.size() == 1) check("full_beats", fin_q[0], 6);
    fin_q.delete();

    // Table-driven packets
    for (int i = 0; i < 5; i++) begin
      tr_mode = tbl[i].mode;
      for (int j = 0; j < tbl[i].len; j++) write_word($urandom, j == tbl[i].len - 1);
      drain();
      check("tbl_fin_count", fin_q.size(), 1);
      if (fin_q.size() == 1) check("tbl_beats", fin_q[0], tbl[i].exp_beats);
      fin_q.delete();
    end

    // Streaming: 20 words, no bubbles, packets of 8 and 12
    tr_mode = 1;
    repeat (2) tick();
    hs_mark = hs_count;
    for (int i = 0; i < 20; i++) write_word(32'h1000 + i, (i == 7) || (i == 19));
    drain();
    check("stream_beat_count", hs_count - hs_mark, 20);
    check("stream_no_bubble", last_hs_cyc - first_hs_cyc, 19);
    check("stream_fin_count", fin_q.size(), 2);
    if (fin_q.size() == 2) begin
      check("stream_beats0", fin_q[0], 8);
      check("stream_beats1", fin_q[1], 12);
    end
    fin_q.delete();

    // Pointer wrap: 37 single-word packets under random tready
    tr_mode = 2;
    for (int i = 0; i < 37; i++) write_word($urandom, 1'b1);
    drain();
    check("wrap_fin_count", fin_q.size(), 37);
    bad = 0;
    foreach (fin_q[k]) if (fin_q[k] != 1) bad++;
    check("wrap_beats_all_one", bad, 0);
    fin_q.delete();

    // Reset mid-packet after beat 2 of 5
    tr_mode = 0;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) write_word(32'h200 + i, i == 4);
    hs_mark = hs_count;
    tr_mode = 1;
    b = 200;
    while ((hs_count - hs_mark) < 2 && b > 0) begin
      tick();
      b--;
    end
    check("abort_reached_beat2", hs_count - hs_mark, 2);
    areset = 1'b1;
    #1;
    check("abort_tvalid_async", tvalid, 1'b0);
    repeat (2) tick();
    areset = 1'b0;
    check("abort_ready", ready, 1'b1);
    check("abort_beats", beats, 16'h0);
    check("abort_finish", finish, 1'b0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tvalid) bad++;
    end
    check("abort_no_stale", bad, 0);
    check("abort_no_finish", fin_q.size(), 0);
    write_word(32'hCAFE_0001, 1'b1);
    drain();
    check("post_abort_fin_count", fin_q.size(), 1);
    if (fin_q.size() == 1) check("post_abort_beats", fin_q[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
